dacif_rx: RTL and testbench

- Serial-to-parallel receiver for the DAC serial link; the far end of the parallel-to-serial DAC controller.
- Deserialises LSB-first frames gated by an active-low frame enable, checks the trailing marker bit and presents the data word plus address bit.
- Holds the latest word per address (channel 0/1) for the DAC model, loopback checker and register readback.

---
 rtl/dacif_rx_pkg.sv | 18 +
 rtl/dacif_rx_sync.sv | 27 ++
 rtl/dacif_rx.sv | 138 +++++++++++++
 tb/tb_dacif_rx.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dacif_rx_pkg.sv
// Shared definitions for the DAC serial link (receiver and transmitter).
package dacif_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  // Trailing marker bit value that terminates every good frame.
  localparam logic MARKER_VAL = 1'b1;

  // Frame length in bits: data word, address bit, marker bit.
  function automatic int frame_len(input int dwidth);
    return dwidth + 2;
  endfunction

endpackage

// File: rtl/dacif_rx_sync.sv
// Two-flop synchroniser with a configurable reset value.
module dacif_rx_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/dacif_rx.sv
// DAC serial link receiver: LSB-first deserialiser with marker check and
// per-address holding registers.
// Build option: DACIF_RX_SYNC_EN inserts 2-flop synchronisers on sdi/dac_scen.
module dacif_rx
  import dacif_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk_4M,
  input  logic              rst,
  input  logic              sdi,
  input  logic              dac_scen,
  output logic [DWIDTH-1:0] rx_data,
  output logic              rx_addr,
  output logic              rx_valid,
  output logic [DWIDTH-1:0] ch0_data,
  output logic [DWIDTH-1:0] ch1_data,
  output logic              frame_err,
  output logic              busy
);

  localparam int FLEN = frame_len(DWIDTH);
  localparam int CW   = $clog2(FLEN);

  logic sdi_s;
  logic scen_s;

`ifdef DACIF_RX_SYNC_EN
  dacif_rx_sync #(.RST_VAL(1'b0)) u_sync_sdi (
    .clk_i (clk_4M),
    .rst_i (rst),
    .d_i   (sdi),
    .q_o   (sdi_s)
  );

  dacif_rx_sync #(.RST_VAL(1'b1)) u_sync_scen (
    .clk_i (clk_4M),
    .rst_i (rst),
    .d_i   (dac_scen),
    .q_o   (scen_s)
  );
`else
  assign sdi_s  = sdi;
  assign scen_s = dac_scen;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DWIDTH:0]   sr_q, sr_d;       // {a, d[DWIDTH-1:0]} once filled
  logic [DWIDTH-1:0] rxd_q, rxd_d;
  logic              rxa_q, rxa_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DWIDTH-1:0] ch0_q, ch0_d;
  logic [DWIDTH-1:0] ch1_q, ch1_d;

  // Register state, counter, shift register and all outputs.
  always_ff @(posedge clk_4M or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      rxd_q   <= '0;
      rxa_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ch0_q   <= '0;
      ch1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      rxd_q   <= rxd_d;
      rxa_q   <= rxa_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
    end
  end

  // Next-state logic. Bits enter at the MSB and shift right, so after
  // DWIDTH+1 captures d[0] sits at bit 0 and the address at bit DWIDTH;
  // the marker is checked straight off the line and never stored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    rxd_d   = rxd_q;
    rxa_d   = rxa_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    ch0_d   = ch0_q;
    ch1_d   = ch1_q;
    case (state_q)
      S_IDLE: begin
        if (!scen_s) begin
          sr_d    = {sdi_s, sr_q[DWIDTH:1]};
          cnt_d   = CW'(1);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (scen_s) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(FLEN - 1)) begin
          state_d = S_HOLD;
          if (sdi_s == MARKER_VAL) begin
            rxd_d   = sr_q[DWIDTH-1:0];
            rxa_d   = sr_q[DWIDTH];
            valid_d = 1'b1;
            if (sr_q[DWIDTH]) ch1_d = sr_q[DWIDTH-1:0];
            else              ch0_d = sr_q[DWIDTH-1:0];
          end else begin
            err_d = 1'b1;
          end
        end else begin
          sr_d  = {sdi_s, sr_q[DWIDTH:1]};
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (scen_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_data   = rxd_q;
  assign rx_addr   = rxa_q;
  assign rx_valid  = valid_q;
  assign frame_err = err_q;
  assign ch0_data  = ch0_q;
  assign ch1_data  = ch1_q;
  assign busy      = (state_q == S_SHIFT);

endmodule

// File: tb/tb_dacif_rx.sv
// Scoreboard bench for dacif_rx: a frame-level model pushes the expected
// pulse (kind, arrival cycle, register contents); a monitor pops on pulses.
module tb_dacif_rx;

`ifdef DACIF_RX_SYNC_EN
  localparam int unsigned LAT = 3;
`else
  localparam int unsigned LAT = 1;
`endif

  logic       clk_4M = 1'b0;
  logic       rst = 1'b1;
  logic       sdi = 1'b0;
  logic       dac_scen = 1'b1;
  logic [7:0] rx_data, ch0_data, ch1_data;
  logic       rx_addr, rx_valid, frame_err, busy;

  dacif_rx #(.DWIDTH(8)) dut (
    .clk_4M    (clk_4M),
    .rst       (rst),
    .sdi       (sdi),
    .dac_scen  (dac_scen),
    .rx_data   (rx_data),
    .rx_addr   (rx_addr),
    .rx_valid  (rx_valid),
    .ch0_data  (ch0_data),
    .ch1_data  (ch1_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk_4M = ~clk_4M;

  typedef struct {
    bit          err;
    logic [7:0]  d;
    logic        a;
    logic [7:0]  c0;
    logic [7:0]  c1;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  // Reference state: what the receiver should be holding.
  logic [7:0] m_rxd = '0;
  logic       m_rxa = 1'b0;
  logic [7:0] m_ch[2] = '{8'h00, 8'h00};

  always @(posedge clk_4M) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input bit err);
    exp_t e;
    e.err = err;
    e.d   = m_rxd;
    e.a   = m_rxa;
    e.c0  = m_ch[0];
    e.c1  = m_ch[1];
    e.cyc = cyc + LAT;
    return e;
  endfunction

  // Monitor: compare every pulse against the head of the queue.
  always @(negedge clk_4M) begin
    if (!rst) begin
      if (rx_valid && frame_err) chk("both_pulses", 1, 0);
      if (q.size() > 0 && q[0].cyc < cyc) begin
        chk("missed_pulse_at", q[0].cyc, 0);
        void'(q.pop_front());
      end
      if (rx_valid || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse_valid_err", {rx_valid, frame_err}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_cycle", cyc, e.cyc);
          chk("pulse_is_err", frame_err, e.err);
          chk("rx_data", rx_data, e.d);
          chk("rx_addr", rx_addr, e.a);
          chk("ch0_data", ch0_data, e.c0);
          chk("ch1_data", ch1_data, e.c1);
          chk("busy_after_frame", busy, 0);
        end
      end
    end
  end

  // Send one frame. nbits<10 aborts after that many bits; extra_low keeps
  // dac_scen low past a complete frame; gap is the idle (high) count.
  task automatic frame(input logic [7:0] d, input logic a, input logic m,
                       input int unsigned nbits, input int unsigned extra_low,
                       input int unsigned gap);
    logic [9:0] bits;
    bits = {m, a, d};
    for (int unsigned i = 0; i < nbits; i++) begin
      @(negedge clk_4M);
      dac_scen = 1'b0;
      sdi = bits[i];
      if (i == 9) begin
        chk("busy_mid_frame", busy, 1);
        if (m) begin
          m_rxd = d;
          m_rxa = a;
          m_ch[a] = d;
          q.push_back(mk(1'b0));
        end else begin
          q.push_back(mk(1'b1));
        end
      end
    end
    for (int unsigned i = 0; i < extra_low && nbits == 10; i++) begin
      @(negedge clk_4M);
      sdi = 1'($urandom);
    end
    for (int unsigned i = 0; i < gap; i++) begin
      @(negedge clk_4M);
      dac_scen = 1'b1;
      sdi = 1'($urandom);
      if (i == 0 && nbits > 0 && nbits < 10) q.push_back(mk(1'b1));
    end
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_rx_data"}, rx_data, 0);
    chk({nm, "_rx_addr"}, rx_addr, 0);
    chk({nm, "_rx_valid"}, rx_valid, 0);
    chk({nm, "_ch0"}, ch0_data, 0);
    chk({nm, "_ch1"}, ch1_data, 0);
    chk({nm, "_frame_err"}, frame_err, 0);
    chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic drain();
    for (int unsigned i = 0; i < 8 && q.size() > 0; i++) @(negedge clk_4M);
    chk("queue_drained", q.size(), 0);
    q.delete();
  endtask

  initial begin
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk_4M);
    rst = 1'b0;
    @(negedge clk_4M);

    // Good frame 0xA5, a=1.
    frame(8'hA5, 1'b1, 1'b1, 10, 0, 2);
    // Bad marker 0x3C, a=0.
    frame(8'h3C, 1'b0, 1'b0, 10, 0, 2);
    // Abort after 4 bits, then 0x5A on channel 0.
    frame(8'hFF, 1'b1, 1'b1, 4, 0, 2);
    frame(8'h5A, 1'b0, 1'b1, 10, 0, 1);
    // dac_scen held low past the frame, then minimum gap.
    frame(8'h11, 1'b0, 1'b1, 10, 20, 1);
    frame(8'h22, 1'b1, 1'b1, 10, 0, 2);
    drain();

    // Reset after 5 bits: immediate clear, no pulses, then recovery.
    frame(8'hC3, 1'b1, 1'b1, 5, 0, 0);
    @(negedge clk_4M);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    m_rxd = '0; m_rxa = 1'b0; m_ch[0] = '0; m_ch[1] = '0;
    dac_scen = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk_4M);
    frame(8'h96, 1'b0, 1'b1, 10, 0, 2);
    drain();

    // Randomised frames.
    for (int unsigned n = 0; n < 60; n++) begin
      logic [7:0]  d;
      logic        a, m;
      int unsigned nb;
      d  = 8'($urandom);
      a  = 1'($urandom);
      m  = ($urandom_range(0, 3) != 0);
      nb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 9) : 10;
      frame(d, a, m, nb, $urandom_range(0, 3), $urandom_range(1, 3));
    end
    repeat (2) @(negedge clk_4M);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
